// File: rtl/add_sub_serial.sv
// rtl/add_sub_serial.sv - digit-serial two's-complement adder/subtractor with start/done handshake
module add_sub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_c;
    logic             msb_cin;
    logic             rip_c;
    logic [WIDTH-1:0] res_next;

    // Operands shift right one digit per cycle, so the active digit is always at the bottom;
    // the result fills from the top so it is aligned after the last digit.
    always_comb begin
        dig_s   = '0;
        rip_c   = carry_q;
        msb_cin = carry_q;
        for (int j = 0; j < DIGIT; j++) begin
            dig_s[j] = a_q[j] ^ b_q[j] ^ rip_c;
            if (j == DIGIT - 1) begin
                msb_cin = rip_c;
            end
            rip_c = (a_q[j] & b_q[j]) | (rip_c & (a_q[j] ^ b_q[j]));
        end
        dig_c    = rip_c;
        res_next = res_q >> DIGIT;
        res_next[WIDTH-1 -: DIGIT] = dig_s;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = mode ? ~b : b;
                    carry_d = mode;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dig_c;
                res_d   = res_next;
                cnt_d   = cnt_q + CW'(1);
                // Visible results only change here, all at once.
                if (cnt_q == LAST_DIG) begin
                    state_d = S_DONE;
                    sum_d   = res_next;
                    cout_d  = dig_c;
                    ovf_d   = msb_cin ^ dig_c;
                    zero_d  = (res_next == '0);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign done  = (state_q == S_DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// tb/tb_add_sub_serial.sv - randomized self-checking bench for add_sub_serial (16/4, 8/8, 8/1)
module tb_add_sub_serial;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start_v = 3'b000;
    logic        mode_i = 1'b0;
    logic [15:0] a_i = '0;
    logic [15:0] b_i = '0;

    logic        ready0, done0, cout0, ovf0, zero0;
    logic [15:0] sum0;
    logic        ready1, done1, cout1, ovf1, zero1;
    logic [7:0]  sum1;
    logic        ready2, done2, cout2, ovf2, zero2;
    logic [7:0]  sum2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    add_sub_serial #(.WIDTH(16), .DIGIT(4)) u_d16 (
        .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode_i), .a(a_i), .b(b_i),
        .ready(ready0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0), .zero(zero0));

    add_sub_serial #(.WIDTH(8), .DIGIT(8)) u_d8w (
        .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode_i), .a(a_i[7:0]), .b(b_i[7:0]),
        .ready(ready1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1));

    add_sub_serial #(.WIDTH(8), .DIGIT(1)) u_d8s (
        .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode_i), .a(a_i[7:0]), .b(b_i[7:0]),
        .ready(ready2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2), .zero(zero2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? ready0 : (sel == 1) ? ready1 : ready2;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
    endfunction

    function automatic logic [15:0] get_sum(input int sel);
        return (sel == 0) ? sum0 : (sel == 1) ? {8'h00, sum1} : {8'h00, sum2};
    endfunction

    function automatic logic [2:0] get_flags(input int sel);
        return (sel == 0) ? {cout0, ovf0, zero0} :
               (sel == 1) ? {cout1, ovf1, zero1} : {cout2, ovf2, zero2};
    endfunction

    // Reference: integer arithmetic on unsigned and signed views of the operands.
    function automatic logic [18:0] ref_op(input int w, input logic m,
                                           input logic [15:0] a, input logic [15:0] b);
        longint mask, half, ua, ub, sa, sb, sres, r;
        logic c, v, z;
        mask = (64'sd1 <<< w) - 1;
        half = 64'sd1 <<< (w - 1);
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        sa = (ua >= half) ? ua - (mask + 1) : ua;
        sb = (ub >= half) ? ub - (mask + 1) : ub;
        if (m) begin
            sres = sa - sb;
            c    = (ua >= ub);
            r    = (ua - ub) & mask;
        end else begin
            sres = sa + sb;
            c    = ((ua + ub) > mask);
            r    = (ua + ub) & mask;
        end
        v = (sres < -half) || (sres >= half);
        z = (r == 0);
        return {c, v, z, r[15:0]};
    endfunction

    function automatic int width_of(input int sel);
        return (sel == 0) ? 16 : 8;
    endfunction

    // Called #1 after a clock edge; returns #1 after the edge following the done pulse.
    task automatic run_op(input int sel, input logic m, input logic [15:0] a, input logic [15:0] b,
                          input int exp_lat);
        int g;
        int lat;
        logic [15:0] prev_sum;
        logic [2:0]  prev_flags;
        logic [18:0] exp;
        g = 0;
        while (!get_ready(sel) && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (!get_ready(sel)) check("ready_wait", 0, 1);
        prev_sum   = get_sum(sel);
        prev_flags = get_flags(sel);
        exp = ref_op(width_of(sel), m, a, b);
        mode_i = m;
        a_i = a;
        b_i = b;
        start_v[sel] = 1'b1;
        @(posedge clk); #1;
        start_v[sel] = 1'b0;
        mode_i = ~m;
        a_i = 16'($urandom);
        b_i = 16'($urandom);
        lat = 0;
        while (!get_done(sel) && lat < 40) begin
            check("ready_low_busy", get_ready(sel), 0);
            @(posedge clk); #1;
            lat++;
            if (!get_done(sel)) begin
                check("sum_hold", get_sum(sel), prev_sum);
                check("flags_hold", get_flags(sel), prev_flags);
            end
        end
        check("done_latency", lat, exp_lat);
        check("sum", get_sum(sel), exp[15:0]);
        check("cout_ovf_zero", get_flags(sel), exp[18:16]);
        @(posedge clk); #1;
        check("done_one_cycle", get_done(sel), 0);
    endtask

    typedef struct {
        logic        m;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
        logic [2:0]  f;
    } dir_t;

    dir_t dir_tab[6] = '{
        '{1'b0, 16'h1234, 16'h0FFF, 16'h2233, 3'b000},
        '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 3'b010},
        '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 3'b101},
        '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 3'b110},
        '{1'b1, 16'h0005, 16'h0005, 16'h0000, 3'b101},
        '{1'b1, 16'h0003, 16'h0005, 16'hFFFE, 3'b000}
    };

    initial begin
        logic [18:0] q[$];
        logic [18:0] e;
        logic        rdy;
        int          last_done;
        int          n_done;
        int          seen;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            check("rst_ready", get_ready(s), 1);
            check("rst_done", get_done(s), 0);
            check("rst_sum", get_sum(s), 0);
            check("rst_flags", get_flags(s), 0);
        end

        for (int i = 0; i < 6; i++) begin
            run_op(0, dir_tab[i].m, dir_tab[i].a, dir_tab[i].b, 4);
            check("dir_sum", get_sum(0), dir_tab[i].s);
            check("dir_flags", get_flags(0), dir_tab[i].f);
        end

        // Abort mid-RUN with a nonzero result already held.
        mode_i = 1'b0; a_i = 16'h1111; b_i = 16'h2222;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_ready", ready0, 1);
        check("abort_done", done0, 0);
        check("abort_sum", sum0, 0);
        check("abort_flags", {cout0, ovf0, zero0}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done0) seen++;
        end
        check("abort_no_done", seen, 0);

        // Continuous start: only operands presented while ready are used.
        last_done = -1;
        n_done = 0;
        for (int cyc = 0; cyc < 48; cyc++) begin
            start_v[0] = (cyc < 36);
            mode_i = 1'($urandom_range(0, 1));
            a_i = 16'($urandom);
            b_i = 16'($urandom);
            rdy = ready0;
            if (rdy && start_v[0]) q.push_back(ref_op(16, mode_i, a_i, b_i));
            @(posedge clk); #1;
            if (done0) begin
                n_done++;
                if (last_done >= 0) check("done_spacing", cyc + 1 - last_done, 6);
                last_done = cyc + 1;
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("hs_sum", sum0, e[15:0]);
                    check("hs_flags", {cout0, ovf0, zero0}, e[18:16]);
                end
            end
        end
        check("hs_queue_empty", q.size(), 0);
        check("hs_done_count", n_done, 6);

        for (int i = 0; i < 60; i++)
            run_op(0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 4);
        for (int i = 0; i < 1000; i++)
            run_op(1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1);
        for (int i = 0; i < 1000; i++)
            run_op(2, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
